// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU instruction sequencer: states, opcodes, fields.
package alu_seq_pkg;

   localparam int unsigned INSTR_W = 16;
   localparam int unsigned FIELD_W = 4;
   localparam int unsigned IMM8_W  = 8;

   // Bit positions of the instruction fields (LSB of each 4-bit field)
   localparam int unsigned OP_LSB    = 12;
   localparam int unsigned RDEST_LSB = 8;
   localparam int unsigned EXT_LSB   = 4;
   localparam int unsigned RSRC_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

   localparam logic [FIELD_W-1:0] OP_RTYPE = 4'b0000;
   localparam logic [FIELD_W-1:0] FN_AND   = 4'b0001;
   localparam logic [FIELD_W-1:0] FN_OR    = 4'b0010;
   localparam logic [FIELD_W-1:0] FN_XOR   = 4'b0011;
   localparam logic [FIELD_W-1:0] FN_ADD   = 4'b0101;
   localparam logic [FIELD_W-1:0] FN_SUB   = 4'b1001;
   localparam logic [FIELD_W-1:0] FN_CMP   = 4'b1011;
   localparam logic [FIELD_W-1:0] FN_MOV   = 4'b1101;

   // Instruction word split into its four nibble fields (MSB first)
   typedef struct packed {
      logic [FIELD_W-1:0] op;
      logic [FIELD_W-1:0] rdest;
      logic [FIELD_W-1:0] ext;
      logic [FIELD_W-1:0] rsrc;
   } instr_t;

   // True for any function code the ALU implements
   function automatic logic is_alu_fn(input logic [FIELD_W-1:0] f);
      return f inside {FN_AND, FN_OR, FN_XOR, FN_ADD, FN_SUB, FN_CMP, FN_MOV};
   endfunction

   // Arithmetic-class functions update the flags
   function automatic logic fn_sets_flags(input logic [FIELD_W-1:0] f);
      return f inside {FN_ADD, FN_SUB, FN_CMP};
   endfunction

   // Arithmetic/move immediates are signed; logical immediates are masks
   function automatic logic fn_imm_signed(input logic [FIELD_W-1:0] f);
      return f inside {FN_ADD, FN_SUB, FN_CMP, FN_MOV};
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake between an instruction source and the sequencer.
interface alu_sequencer_if;
   import alu_seq_pkg::*;

   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;

   modport master (output instr_valid, output instr, input instr_ready);
   modport slave  (input instr_valid, input instr, output instr_ready);

endinterface

// File: rtl/alu_instr_decode.sv
// Combinational decoder: instruction word to datapath controls.
module alu_instr_decode
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OP_W   = 8
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [OP_W-1:0]    alu_op,
   output logic [4:0]         muxA,
   output logic [4:0]         muxB,
   output logic [DATA_W-1:0]  imm,
   output logic               imm_control,
   output logic               writes_reg,
   output logic               sets_flags,
   output logic               illegal
);

   instr_t              f;
   logic [IMM8_W-1:0]   imm8;
   logic [FIELD_W-1:0]  fn;

   assign f    = instr_t'(instr);
   assign imm8 = {f.ext, f.rsrc};

   // Illegal words produce all-zero controls so nothing downstream moves
   always_comb begin
      alu_op      = '0;
      muxA        = '0;
      muxB        = '0;
      imm         = '0;
      imm_control = 1'b0;
      writes_reg  = 1'b0;
      sets_flags  = 1'b0;
      illegal     = 1'b0;
      fn          = (f.op == OP_RTYPE) ? f.ext : f.op;

      if (f.op == OP_RTYPE && is_alu_fn(f.ext)) begin
         alu_op = OP_W'(f.ext);
         muxA   = {1'b0, f.rdest};
         muxB   = {1'b0, f.rsrc};
      end else if (f.op != OP_RTYPE && is_alu_fn(f.op)) begin
         alu_op      = OP_W'(f.op);
         muxA        = {1'b0, f.rdest};
         imm_control = 1'b1;
         imm         = fn_imm_signed(f.op) ? DATA_W'($signed(imm8)) : DATA_W'(imm8);
      end else begin
         illegal = 1'b1;
      end

      if (!illegal) begin
         writes_reg = (fn != FN_CMP);
         sets_flags = fn_sets_flags(fn);
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer: accepts one instruction, then drives DECODE/EXEC/WB controls.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned OP_W   = 8
) (
   input  logic              clk,
   input  logic              reset,
   alu_sequencer_if.slave    bus,
   output logic [OP_W-1:0]   alu_op,
   output logic [4:0]        muxA,
   output logic [4:0]        muxB,
   output logic [DATA_W-1:0] imm,
   output logic              imm_control,
   output logic              flag_en,
   output logic              buff_en,
   output logic [NREGS-1:0]  regs_en,
   output logic              done,
   output logic              illegal
);

   state_t              state, state_next;
   logic [INSTR_W-1:0]  instr_q;
   logic [INSTR_W-1:0]  instr_cur_c;
   logic                accept_c;
   logic                ready;

   logic [OP_W-1:0]     dec_alu_op;
   logic [4:0]          dec_muxA, dec_muxB;
   logic [DATA_W-1:0]   dec_imm;
   logic                dec_imm_control, dec_writes_reg, dec_sets_flags, dec_illegal;

   logic [OP_W-1:0]     alu_op_d;
   logic [4:0]          muxA_d, muxB_d;
   logic [DATA_W-1:0]   imm_d;
   logic                imm_control_d, flag_en_d, buff_en_d, done_d, illegal_d, ready_d;
   logic [NREGS-1:0]    regs_en_d;

   assign bus.instr_ready = ready;
   assign accept_c        = (state == ST_IDLE) && bus.instr_valid;
   // Decode the incoming word on the accept edge so DECODE-cycle controls are already registered
   assign instr_cur_c     = accept_c ? bus.instr : instr_q;

   alu_instr_decode #(.DATA_W(DATA_W), .OP_W(OP_W)) u_decode (
      .instr       (instr_cur_c),
      .alu_op      (dec_alu_op),
      .muxA        (dec_muxA),
      .muxB        (dec_muxB),
      .imm         (dec_imm),
      .imm_control (dec_imm_control),
      .writes_reg  (dec_writes_reg),
      .sets_flags  (dec_sets_flags),
      .illegal     (dec_illegal)
   );

   // Next state and the output values belonging to that next state
   always_comb begin
      state_next    = state;
      alu_op_d      = '0;
      muxA_d        = '0;
      muxB_d        = '0;
      imm_d         = '0;
      imm_control_d = 1'b0;
      flag_en_d     = 1'b0;
      buff_en_d     = 1'b0;
      regs_en_d     = '0;
      done_d        = 1'b0;
      illegal_d     = 1'b0;
      ready_d       = 1'b0;

      case (state)
         ST_IDLE:   if (accept_c) state_next = ST_DECODE;
         ST_DECODE: state_next = dec_illegal ? ST_IDLE : ST_EXEC;
         ST_EXEC:   state_next = ST_WB;
         ST_WB:     state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase

      if (state_next != ST_IDLE) begin
         alu_op_d      = dec_alu_op;
         muxA_d        = dec_muxA;
         muxB_d        = dec_muxB;
         imm_d         = dec_imm;
         imm_control_d = dec_imm_control;
      end

      case (state_next)
         ST_IDLE:   ready_d   = 1'b1;
         ST_DECODE: illegal_d = dec_illegal;
         ST_EXEC:   flag_en_d = dec_sets_flags;
         ST_WB: begin
            buff_en_d = 1'b1;
            done_d    = 1'b1;
            if (dec_writes_reg) regs_en_d = NREGS'(1) << dec_muxA[3:0];
         end
         default: ready_d = 1'b1;
      endcase
   end

   // State, latched instruction and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         instr_q     <= '0;
         ready       <= 1'b1;
         alu_op      <= '0;
         muxA        <= '0;
         muxB        <= '0;
         imm         <= '0;
         imm_control <= 1'b0;
         flag_en     <= 1'b0;
         buff_en     <= 1'b0;
         regs_en     <= '0;
         done        <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         state       <= state_next;
         if (accept_c) instr_q <= bus.instr;
         ready       <= ready_d;
         alu_op      <= alu_op_d;
         muxA        <= muxA_d;
         muxB        <= muxB_d;
         imm         <= imm_d;
         imm_control <= imm_control_d;
         flag_en     <= flag_en_d;
         buff_en     <= buff_en_d;
         regs_en     <= regs_en_d;
         done        <= done_d;
         illegal     <= illegal_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: directed cases plus random traffic against a latency-based model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  alu_op;
   logic [4:0]  muxA, muxB;
   logic [15:0] imm;
   logic        imm_control, flag_en, buff_en, done, illegal;
   logic [15:0] regs_en;

   alu_sequencer_if bus ();

   alu_sequencer #(.DATA_W(16), .NREGS(16), .OP_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus.slave),
      .alu_op      (alu_op),
      .muxA        (muxA),
      .muxB        (muxB),
      .imm         (imm),
      .imm_control (imm_control),
      .flag_en     (flag_en),
      .buff_en     (buff_en),
      .regs_en     (regs_en),
      .done        (done),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: an instruction accepted at cycle acc occupies cycles acc+1 .. acc+len-1
   bit          have = 1'b0;
   int          acc  = 0;
   logic [15:0] m_instr = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit is_fn(input int f);
      return (f == 1 || f == 2 || f == 3 || f == 5 || f == 9 || f == 11 || f == 13);
   endfunction

   // Field-level meaning of an instruction word
   function automatic void ref_dec(input logic [15:0] w, output bit ill, output int aop,
                                   output int ma, output int mb, output int im, output int ic,
                                   output int wr, output int fl);
      int op, rd, ex, rs, i8, f;
      op = int'(w[15:12]); rd = int'(w[11:8]); ex = int'(w[7:4]); rs = int'(w[3:0]);
      i8 = int'(w[7:0]);
      ill = 1'b0; aop = 0; ma = 0; mb = 0; im = 0; ic = 0; wr = 0; fl = 0;
      if (op == 0 && is_fn(ex)) begin
         aop = ex; ma = rd; mb = rs; f = ex;
      end else if (op != 0 && is_fn(op)) begin
         aop = op; ma = rd; ic = 1; f = op;
         if (op == 1 || op == 2 || op == 3) im = i8;
         else im = (i8 >= 128) ? i8 + 65280 : i8;
      end else begin
         ill = 1'b1; f = 0;
      end
      if (!ill) begin
         wr = (f != 11) ? 1 : 0;
         fl = (f == 5 || f == 9 || f == 11) ? 1 : 0;
      end
   endfunction

   function automatic int inst_len(input logic [15:0] w);
      bit ill; int a, b, c, d, e, g, h;
      ref_dec(w, ill, a, b, c, d, e, g, h);
      return ill ? 2 : 4;
   endfunction

   function automatic bit model_ready(input int c);
      int off;
      off = c - acc;
      return !(have && off >= 1 && off < inst_len(m_instr));
   endfunction

   task automatic compare_all();
      bit ill; int aop, ma, mb, im, ic, wr, fl, off;
      bit busy;
      off  = cyc - acc;
      busy = !model_ready(cyc);
      ref_dec(m_instr, ill, aop, ma, mb, im, ic, wr, fl);
      if (!busy) begin
         aop = 0; ma = 0; mb = 0; im = 0; ic = 0;
      end
      check("instr_ready", 32'(bus.instr_ready), busy ? 0 : 1);
      check("alu_op",      32'(alu_op),      32'(aop));
      check("muxA",        32'(muxA),        32'(ma));
      check("muxB",        32'(muxB),        32'(mb));
      check("imm",         32'(imm),         32'(im));
      check("imm_control", 32'(imm_control), 32'(ic));
      check("illegal",     32'(illegal),     (busy && off == 1 && ill) ? 1 : 0);
      check("flag_en",     32'(flag_en),     (busy && off == 2) ? 32'(fl) : 0);
      check("buff_en",     32'(buff_en),     (busy && off == 3) ? 1 : 0);
      check("done",        32'(done),        (busy && off == 3) ? 1 : 0);
      check("regs_en",     32'(regs_en),     (busy && off == 3 && wr != 0) ? (32'd1 << ma) : 0);
   endtask

   // One clock: apply inputs, advance model across the edge, check at the falling edge
   task automatic step(input logic r, input logic v, input logic [15:0] w);
      bit rdy;
      reset = r; bus.instr_valid = v; bus.instr = w;
      rdy = model_ready(cyc);
      @(posedge clk);
      if (r) have = 1'b0;
      else if (rdy && v) begin have = 1'b1; acc = cyc; m_instr = w; end
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic issue(input logic [15:0] w, input int idle);
      step(1'b0, 1'b1, w);
      for (int k = 0; k < idle; k++) step(1'b0, 1'b0, 16'($urandom));
   endtask

   logic [15:0] rw;
   int          legal_fns[7] = '{1, 2, 3, 5, 9, 11, 13};

   initial begin
      reset = 1'b1; bus.instr_valid = 1'b0; bus.instr = '0;
      @(negedge clk);
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);

      issue(16'h0355, 4);   // ADD R3,R5
      issue(16'h52FF, 4);   // ADDI R2,#-1
      issue(16'h1780, 4);   // ANDI R7,#0x80
      issue(16'h01B4, 4);   // CMP R1,R4
      issue(16'hF000, 3);   // illegal op
      issue(16'h00F3, 3);   // register form, unlisted ext

      // Held valid: only one accept per four cycles
      for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 16'h0355);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);
      step(1'b0, 1'b0, 16'h0);

      // Reset while in EXEC aborts the write
      step(1'b0, 1'b1, 16'h0355);
      step(1'b0, 1'b0, 16'h0);
      step(1'b1, 1'b0, 16'h0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 16'h0);

      // Random traffic
      for (int k = 0; k < 2000; k++) begin
         case ($urandom_range(3))
            0: rw = 16'($urandom);
            1: rw = {4'h0, 4'($urandom), 4'(legal_fns[$urandom_range(6)]), 4'($urandom)};
            default: rw = {4'(legal_fns[$urandom_range(6)]), 12'($urandom)};
         endcase
         step(($urandom_range(60) == 0), ($urandom_range(2) != 0), rw);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
